// File: rtl/register_bank_if.sv
// ---------------------------------------------------------------------------
// register_bank_if
// Bus bundle for the 16-entry register bank.
//   destination : write index (4 bits)
//   source_1/2  : read-port indices (4 bits each)
//   reg_data    : write data (DATA_W)
//   write_en    : write strobe, active high
//   Result_1/2  : combinational read data (DATA_W)
//   r0..r15     : continuous debug view of every register (DATA_W each)
// The bank is the slave; whoever drives the indices and data is the master.
// ---------------------------------------------------------------------------
interface register_bank_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        destination;
  logic [3:0]        source_1;
  logic [3:0]        source_2;
  logic [DATA_W-1:0] reg_data;
  logic              write_en;
  logic [DATA_W-1:0] Result_1;
  logic [DATA_W-1:0] Result_2;
  logic [DATA_W-1:0] r0,  r1,  r2,  r3;
  logic [DATA_W-1:0] r4,  r5,  r6,  r7;
  logic [DATA_W-1:0] r8,  r9,  r10, r11;
  logic [DATA_W-1:0] r12, r13, r14, r15;

  modport master (
    output destination, source_1, source_2, reg_data, write_en,
    input  Result_1, Result_2,
    input  r0, r1, r2, r3, r4, r5, r6, r7,
    input  r8, r9, r10, r11, r12, r13, r14, r15
  );

  modport slave (
    input  destination, source_1, source_2, reg_data, write_en,
    output Result_1, Result_2,
    output r0, r1, r2, r3, r4, r5, r6, r7,
    output r8, r9, r10, r11, r12, r13, r14, r15
  );
endinterface

// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
// Sixteen general-purpose DATA_W-bit registers, one write port, two
// combinational read ports and a full debug view of every register.
//   Clk   : rising-edge clock for writes
//   Reset : asynchronous active-low clear of all registers
//   bus   : register_bank_if slave modport (indices, data, strobe, results,
//           debug outputs r0..r15)
// Reads have no write bypass: a read of the index being written shows the
// old value until the edge and the new value after it.
// ---------------------------------------------------------------------------
module register_bank #(
  parameter int DATA_W = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  register_bank_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];

  // Next-state: only the addressed register takes the write data.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.write_en) begin
      regs_d[bus.destination] = bus.reg_data;
    end else begin
      regs_d[bus.destination] = regs_q[bus.destination];
    end
  end

  // Register storage with asynchronous clear; reset wins over any pending write.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.Result_1 = regs_q[bus.source_1];
  assign bus.Result_2 = regs_q[bus.source_2];

  assign bus.r0  = regs_q[0];
  assign bus.r1  = regs_q[1];
  assign bus.r2  = regs_q[2];
  assign bus.r3  = regs_q[3];
  assign bus.r4  = regs_q[4];
  assign bus.r5  = regs_q[5];
  assign bus.r6  = regs_q[6];
  assign bus.r7  = regs_q[7];
  assign bus.r8  = regs_q[8];
  assign bus.r9  = regs_q[9];
  assign bus.r10 = regs_q[10];
  assign bus.r11 = regs_q[11];
  assign bus.r12 = regs_q[12];
  assign bus.r13 = regs_q[13];
  assign bus.r14 = regs_q[14];
  assign bus.r15 = regs_q[15];

endmodule

// File: tb/tb_register_bank.sv
// ---------------------------------------------------------------------------
// tb_register_bank
// Directed stimulus with hand-computed expectations. Each expectation is
// pushed to a scoreboard queue; a separate monitor process pops and compares
// whenever the stimulus signals that the outputs are ready to observe.
// Selector codes: 0 = Result_1, 1 = Result_2, 2+k = debug output rk.
// ---------------------------------------------------------------------------
module tb_register_bank;

  localparam int DATA_W = 32;

  logic Clk;
  logic Reset;

  register_bank_if #(.DATA_W(DATA_W)) bus ();

  register_bank #(.DATA_W(DATA_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int                sel;
    logic [DATA_W-1:0] exp;
    string             name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  event sample_ev;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [DATA_W-1:0] get_act(input int sel);
    case (sel)
      0:       return bus.Result_1;
      1:       return bus.Result_2;
      2:       return bus.r0;
      3:       return bus.r1;
      4:       return bus.r2;
      5:       return bus.r3;
      6:       return bus.r4;
      7:       return bus.r5;
      8:       return bus.r6;
      9:       return bus.r7;
      10:      return bus.r8;
      11:      return bus.r9;
      12:      return bus.r10;
      13:      return bus.r11;
      14:      return bus.r12;
      15:      return bus.r13;
      16:      return bus.r14;
      17:      return bus.r15;
      default: return {DATA_W{1'bx}};
    endcase
  endfunction

  // Monitor: drain the scoreboard each time outputs are declared observable.
  initial begin
    exp_t e;
    logic [DATA_W-1:0] act;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = get_act(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic push_exp(input int sel, input logic [DATA_W-1:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic observe();
    -> sample_ev;
    #1;
  endtask

  // Drive a write at the falling edge; it lands on the following rising edge.
  task automatic write_reg(input logic [3:0] dst, input logic [DATA_W-1:0] data);
    @(negedge Clk);
    bus.destination = dst;
    bus.reg_data    = data;
    bus.write_en    = 1'b1;
    @(posedge Clk);
    #1;
    bus.write_en    = 1'b0;
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset           = 1'b0;
    bus.destination = 4'd0;
    bus.source_1    = 4'd0;
    bus.source_2    = 4'd0;
    bus.reg_data    = 32'h0000_0000;
    bus.write_en    = 1'b0;

    // Write attempted during reset must be ignored.
    @(negedge Clk);
    bus.destination = 4'd6;
    bus.reg_data    = 32'h1111_1111;
    bus.write_en    = 1'b1;
    @(posedge Clk);
    #1;
    bus.write_en    = 1'b0;
    push_exp(8, 32'h0000_0000, "write_ignored_in_reset_r6");
    observe();

    // Release reset; everything reads zero.
    @(negedge Clk);
    Reset        = 1'b1;
    bus.source_1 = 4'd3;
    bus.source_2 = 4'd15;
    #1;
    push_exp(0, 32'h0000_0000, "reset_Result_1");
    push_exp(1, 32'h0000_0000, "reset_Result_2");
    for (int k = 0; k < 16; k++) begin
      push_exp(2 + k, 32'h0000_0000, $sformatf("reset_r%0d", k));
    end
    observe();

    // Back-to-back writes to R1 and R2.
    write_reg(4'd1, 32'd10);
    write_reg(4'd2, 32'd20);
    bus.source_1 = 4'd1;
    bus.source_2 = 4'd2;
    #1;
    push_exp(0, 32'd10, "rd_R1_port1");
    push_exp(1, 32'd20, "rd_R2_port2");
    push_exp(3, 32'd10, "dbg_r1");
    push_exp(4, 32'd20, "dbg_r2");
    observe();

    // write_en low: nothing changes.
    @(negedge Clk);
    bus.destination = 4'd1;
    bus.reg_data    = 32'd99;
    bus.write_en    = 1'b0;
    @(posedge Clk);
    #1;
    push_exp(3, 32'd10, "no_write_r1_hold");
    observe();

    // Read during write to the same index: old before, new after the edge.
    @(negedge Clk);
    bus.source_1    = 4'd5;
    bus.destination = 4'd5;
    bus.reg_data    = 32'hDEAD_BEEF;
    bus.write_en    = 1'b1;
    #1;
    push_exp(0, 32'h0000_0000, "rdw_before_edge");
    observe();
    @(posedge Clk);
    #1;
    bus.write_en = 1'b0;
    push_exp(0, 32'hDEAD_BEEF, "rdw_after_edge");
    push_exp(7, 32'hDEAD_BEEF, "rdw_dbg_r5");
    observe();

    // Both ports on the same index.
    write_reg(4'd7, 32'd42);
    bus.source_1 = 4'd7;
    bus.source_2 = 4'd7;
    #1;
    push_exp(0, 32'd42, "same_idx_port1");
    push_exp(1, 32'd42, "same_idx_port2");
    observe();

    // R0 is an ordinary register; bit-exact storage of the MSB pattern.
    write_reg(4'd0, 32'h1234_5678);
    write_reg(4'd4, 32'h8000_0000);
    bus.source_1 = 4'd0;
    bus.source_2 = 4'd4;
    #1;
    push_exp(0, 32'h1234_5678, "r0_not_hardwired");
    push_exp(1, 32'h8000_0000, "msb_bit_exact");
    observe();

    // Fill R15, then reset mid-cycle with a write pending.
    write_reg(4'd15, 32'hFFFF_FFFF);
    bus.source_1 = 4'd15;
    #1;
    push_exp(17, 32'hFFFF_FFFF, "r15_all_ones");
    observe();
    @(negedge Clk);
    bus.destination = 4'd3;
    bus.reg_data    = 32'h0000_0055;
    bus.write_en    = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    push_exp(17, 32'h0000_0000, "async_reset_r15");
    push_exp(0,  32'h0000_0000, "async_reset_Result_1");
    push_exp(9,  32'h0000_0000, "async_reset_r7");
    observe();
    @(posedge Clk);
    #1;
    push_exp(5, 32'h0000_0000, "reset_overrides_write_r3");
    observe();

    // First edge after release accepts the pending write.
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    bus.write_en = 1'b0;
    push_exp(5, 32'h0000_0055, "first_write_after_reset");
    observe();

    #5;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
- REQ-001: The block SHALL have parameter DATA_W, default 32, giving the register and data-port width in bits.
- REQ-002: The block SHALL have one clock, `Clk`, and one reset, `Reset`; reset is asynchronous and active-low.
- REQ-003: Clk  input  1  rising-edge clock for all register writes.
- REQ-004: Reset  input  1  asynchronous active-low reset; low clears all registers.
- REQ-005: destination  input  4  index of the register written at the next rising `Clk` edge.
- REQ-006: source_1  input  4  read-port-1 register index.
- REQ-007: source_2  input  4  read-port-2 register index.
- REQ-008: reg_data  input  DATA_W  write data.
- REQ-009: write_en  input  1  write strobe, active high.
- REQ-010: Result_1  output  DATA_W  contents of register[source_1].
- REQ-011: Result_2  output  DATA_W  contents of register[source_2].
- REQ-012: r0..r15  output  DATA_W each  continuous debug view of registers 0..15.

Function
- REQ-013: The block SHALL hold 16 general registers, R0..R15, each DATA_W bits wide; no register is hard-wired or special.
- REQ-014: On a rising `Clk` edge with `Reset` high and `write_en` high, register[destination] SHALL load `reg_data`; all other registers SHALL hold.
- REQ-015: With `write_en` low, a rising `Clk` edge SHALL leave every register unchanged.
- REQ-016: Read ports SHALL be combinational: `Result_1`/`Result_2` follow changes to source indices and register contents within the same cycle, with no clock latency.
- REQ-017: Read during write to the same index SHALL return the old value before the edge and the new value after the edge; there is no bypass path.
- REQ-018: `source_1` and `source_2` MAY be equal or may equal `destination`; both ports SHALL then return identical data.
- REQ-019: Debug outputs r0..r15 SHALL always equal R0..R15 respectively and update immediately after each write edge.
- REQ-020: Values SHALL be stored bit-exact, with no sign handling, truncation, or extension.
- REQ-021: The block SHALL contain no X-producing paths; every output is defined at all times after reset.

Reset
- REQ-022: `Reset` low SHALL immediately, without waiting for `Clk`, clear R0..R15 to 0, driving `Result_1`, `Result_2` and r0..r15 to 0.
- REQ-023: While `Reset` is low, writes SHALL be ignored regardless of `write_en`.
- REQ-024: Reset asserted mid-cycle SHALL override any write pending on the next edge.
- REQ-025: The first write SHALL be accepted on the first rising `Clk` edge after `Reset` goes high.

Verification
- REQ-026: Assert Reset low, then release; with source_1=3 and source_2=15 -> Result_1=0, Result_2=0, r0..r15=0.
- REQ-027: Write 10 to R1 and 20 to R2 on successive edges; set source_1=1, source_2=2 -> Result_1=10, Result_2=20, r1=10, r2=20.
- REQ-028: Set write_en=0, destination=1, reg_data=99, and apply an edge -> r1 stays 10.
- REQ-029: Set source_1=5, destination=5, reg_data=0xDEADBEEF with write_en=1 -> Result_1 shows the old value before the edge and 0xDEADBEEF after it.
- REQ-030: Write 0xFFFFFFFF to R15, then pulse Reset low between clock edges -> r15=0 immediately, with no edge required.
- REQ-031: Set source_1=source_2=7 after writing 42 to R7 -> both ports read 42.
